sp_inst_issuer: RTL and testbench

//  Instruction source and result reader for the 4-register add/sub/and pipeline.

---
 rtl/sp_inst_issuer.sv | 160 ++++++++++++++++
 tb/tb_sp_inst_issuer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_inst_issuer.sv
`timescale 1ns/1ps
// Instruction issuer for the 4-register pipeline: buffers host words, issues them,
// drains with NOPs, then reads back registers 0..3 on a dump stream.
module sp_inst_issuer #(
    parameter int DEPTH        = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_inst,
    output logic       in_ready,
    input  logic       start,
    output logic [7:0] inst,
    output logic       busy,
    output logic [7:0] issue_cnt,
    output logic [1:0] dump_rd,
    input  logic [7:0] dump_data,
    output logic       dump_valid,
    output logic [1:0] dump_idx,
    output logic [7:0] dump_val,
    output logic       done
);
    // state | meaning
    // IDLE  | waiting for start, inst = NOP
    // ISSUE | popping one FIFO word per cycle onto inst
    // DRAIN | NOPs while the pipeline finishes writeback
    // DUMP  | reading register file index 0..3
    // DONE  | dump complete, done held until next start

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DUMP, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [7:0]  r_inst;
    logic [7:0]  r_issue_cnt;
    logic [3:0]  r_cnt;
    logic [1:0]  r_idx;
    logic        r_dump_valid;
    logic [1:0]  r_dump_idx;
    logic [7:0]  r_dump_val;
    logic        r_done;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_accept;
    logic w_load_drain;
    logic w_drain_end;

    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_push   = in_valid && !w_full;
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = w_empty ? S_DRAIN : S_ISSUE;
            S_ISSUE:        if (w_empty) w_next = S_DRAIN;
            S_DRAIN:        if (r_cnt == 4'd0) w_next = S_DUMP;
            S_DUMP:         if (r_idx == 2'd3) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop        = 1'b0;
        w_load_drain = 1'b0;
        w_drain_end  = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_pop        = w_accept && !w_empty;
                w_load_drain = w_accept && w_empty;
            end
            S_ISSUE: begin
                busy         = 1'b1;
                w_pop        = !w_empty;
                w_load_drain = w_empty;
            end
            S_DRAIN: begin
                busy        = 1'b1;
                w_drain_end = (r_cnt == 4'd0);
            end
            S_DUMP:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign in_ready   = !w_full;
    assign inst       = r_inst;
    assign issue_cnt  = r_issue_cnt;
    assign dump_rd    = r_idx;
    assign dump_valid = r_dump_valid;
    assign dump_idx   = r_dump_idx;
    assign dump_val   = r_dump_val;
    assign done       = r_done;

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= in_inst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst       <= 8'h00;
            r_issue_cnt  <= 8'd0;
            r_cnt        <= 4'd0;
            r_idx        <= 2'd0;
            r_dump_valid <= 1'b0;
            r_dump_idx   <= 2'd0;
            r_dump_val   <= 8'h00;
            r_done       <= 1'b0;
        end else begin
            r_inst <= w_pop ? r_mem[r_rptr[AW-1:0]] : 8'h00;

            if (w_accept)                          r_issue_cnt <= w_empty ? 8'd0 : 8'd1;
            else if (r_state == S_ISSUE && w_pop)  r_issue_cnt <= r_issue_cnt + 8'd1;

            if (w_load_drain)                      r_cnt <= 4'(DRAIN_CYCLES - 1);
            else if (r_state == S_DRAIN && !w_drain_end) r_cnt <= r_cnt - 4'd1;

            if (w_drain_end)              r_idx <= 2'd0;
            else if (r_state == S_DUMP)   r_idx <= r_idx + 2'd1;

            // Capture is one cycle behind the read index, so valid trails DUMP by one.
            r_dump_valid <= (r_state == S_DUMP);
            if (r_state == S_DUMP) begin
                r_dump_idx <= r_idx;
                r_dump_val <= dump_data;
            end

            if (w_accept)                r_done <= 1'b0;
            else if (r_state == S_DONE)  r_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sp_inst_issuer.sv
`timescale 1ns/1ps
// Bench for sp_inst_issuer: vector table of fill/run cases plus hand-written
// sequences for issue order, empty-start timing and mid-run reset.
module tb_sp_inst_issuer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_inst = 8'h00;
    logic       start = 1'b0;
    logic       in_ready, busy, dump_valid, done;
    logic [7:0] inst, issue_cnt, dump_val, dump_data;
    logic [1:0] dump_rd, dump_idx;
    logic [7:0] dbase = 8'h10;

    sp_inst_issuer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .start(start), .inst(inst), .busy(busy),
        .issue_cnt(issue_cnt), .dump_rd(dump_rd), .dump_data(dump_data),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_val(dump_val),
        .done(done)
    );

    assign dump_data = dbase + {6'd0, dump_rd};
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         dumps_seen = 0;
    logic [7:0] exp_inst_q [$];
    logic [9:0] exp_dump_q [$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (inst != 8'h00) begin
                if (exp_inst_q.size() == 0) check("inst_unexpected", int'(inst), 0);
                else                        check("inst_order", int'(inst), int'(exp_inst_q.pop_front()));
            end
            if (dump_valid) begin
                logic [9:0] e;
                dumps_seen++;
                if (exp_dump_q.size() == 0) check("dump_unexpected", int'(dump_idx), 4);
                else begin
                    e = exp_dump_q.pop_front();
                    check("dump_idx", int'(dump_idx), int'(e[9:8]));
                    check("dump_val", int'(dump_val), int'(e[7:0]));
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        exp_inst_q.delete(); exp_dump_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dumps_seen = 0;
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] w, input int exp_ready);
        in_valid = 1'b1; in_inst = w;
        check("in_ready_on_push", int'(in_ready), exp_ready);
        if (exp_ready != 0) exp_inst_q.push_back(w);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ii;
            ii = 2'(i);
            exp_dump_q.push_back({ii, dbase + 8'(i)});
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    typedef struct {
        int         n;
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] db;
        int         exp_ready;
        int         exp_cnt;
    } vec_t;

    vec_t vt [4];

    initial begin
        int cyc;
        vt[0] = '{n: 1, base: 8'h81, step: 8'h00, db: 8'h10, exp_ready: 1, exp_cnt: 1};
        vt[1] = '{n: 5, base: 8'h11, step: 8'h13, db: 8'hA0, exp_ready: 1, exp_cnt: 5};
        vt[2] = '{n: 8, base: 8'h02, step: 8'h05, db: 8'h3C, exp_ready: 0, exp_cnt: 8};
        vt[3] = '{n: 9, base: 8'h21, step: 8'h07, db: 8'hF0, exp_ready: 0, exp_cnt: 8};

        // reset values
        #1;
        check("rst_inst", int'(inst), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dump_valid", int'(dump_valid), 0);
        check("rst_issue_cnt", int'(issue_cnt), 0);
        check("rst_dump_rd", int'(dump_rd), 0);
        check("rst_dump_val", int'(dump_val), 0);
        do_reset();

        // table-driven fill and run
        for (int t = 0; t < 4; t++) begin
            do_reset();
            dbase = vt[t].db;
            for (int i = 0; i < vt[t].n; i++)
                push(8'(vt[t].base + 8'(i) * vt[t].step), (i < 8) ? 1 : 0);
            check("in_ready_after_fill", int'(in_ready), vt[t].exp_ready);
            pulse_start();
            check("busy_after_start", int'(busy), 1);
            wait_done(cyc);
            check("vec_issue_cnt", int'(issue_cnt), vt[t].exp_cnt);
            check("vec_inst_left", exp_inst_q.size(), 0);
            check("vec_dumps_seen", dumps_seen, 4);
            check("vec_busy_at_done", int'(busy), 0);
            check("vec_in_ready_at_done", int'(in_ready), 1);
        end

        // back-to-back issue of three words
        do_reset();
        dbase = 8'h10;
        push(8'h45, 1); push(8'h5A, 1); push(8'hBF, 1);
        pulse_start();
        check("b2b_w0", int'(inst), 'h45);
        @(negedge clk); check("b2b_w1", int'(inst), 'h5A);
        @(negedge clk); check("b2b_w2", int'(inst), 'hBF);
        @(negedge clk); check("b2b_nop", int'(inst), 0);
        wait_done(cyc);
        check("b2b_issue_cnt", int'(issue_cnt), 3);
        check("b2b_dumps", dumps_seen, 4);

        // empty start: 2 drain + 4 dump busy cycles, start during dump ignored
        do_reset();
        dbase = 8'h10;
        begin
            int nbusy, first_dv, first_done, overlap;
            nbusy = 0; first_dv = -1; first_done = -1; overlap = 0;
            pulse_start();
            for (int k = 0; k < 20; k++) begin
                if (busy) nbusy++;
                if (dump_valid && first_dv < 0) first_dv = k;
                if (done && first_done < 0) first_done = k;
                if (dump_valid && done) overlap++;
                start = (k == 4);
                @(negedge clk);
            end
            start = 1'b0;
            check("empty_busy_cycles", nbusy, 6);
            check("empty_first_dump", first_dv, 3);
            check("empty_first_done", first_done, 7);
            check("empty_valid_done_overlap", overlap, 0);
            check("empty_issue_cnt", int'(issue_cnt), 0);
            check("empty_dumps", dumps_seen, 4);
        end

        // restart from DONE clears done
        dbase = 8'h55;
        pulse_start();
        check("restart_done_clear", int'(done), 0);
        wait_done(cyc);
        check("restart_cycles", cyc, 7);

        // mid-run reset with words still buffered
        do_reset();
        dbase = 8'h10;
        push(8'h31, 1); push(8'h32, 1); push(8'h33, 1); push(8'h34, 1);
        pulse_start();
        @(negedge clk);
        check("midrst_pre_inst", int'(inst), 'h32);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_inst", int'(inst), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_issue_cnt", int'(issue_cnt), 0);
        exp_inst_q.delete(); exp_dump_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        dumps_seen = 0;
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready), 1);
        pulse_start();
        wait_done(cyc);
        check("midrst_empty_cycles", cyc, 7);
        check("midrst_issue_cnt_after", int'(issue_cnt), 0);
        check("midrst_dumps", dumps_seen, 4);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
